// File: rtl/serial_pkg.sv
// Shared definitions for the asynchronous serial link (transmitter and receiver).
// Holds the transmitter state encoding and the line levels both ends agree on.
// No logic here; imported by serial_tx and its interface users.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_tx_if.sv
// Parallel word handshake between a producer and the serial transmitter.
// Latency: none, plain wires.
// Backpressure: a word moves only on a clock edge where valid and ready are both high.
interface serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bit_timer.sv
// Bit-period timer: counts clock cycles inside one serial bit and flags the last one.
// Latency: tick is decoded from the registered count, high in the final cycle of each period.
// Backpressure: none; enable low freezes the count, clear restarts it at zero.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int            CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // Cycle counter wraps to zero on the last cycle of each bit period.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: sends start bit, WIDTH data bits LSB first, [parity], stop bit.
// Latency: start bit on the line the cycle after the transfer edge; frame (WIDTH+2)*BIT_CYCLES cycles.
// Backpressure: ready only in IDLE; valid is ignored while a frame is in flight.
// Optional even-parity bit after the data bits when SERIAL_TX_PARITY_EN is defined.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    serial_tx_if.slave tx,
    output logic       serial_out,
    output logic       busy,
    output logic       done
);
    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        state;
    tx_state_t        next_state;
    logic [WIDTH-1:0] shift;
    logic [BW-1:0]    bit_cnt;
    logic             tick;
    logic             in_idle;
    logic             take;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity;
`endif

    assign in_idle = (state == IDLE);
    assign take    = tx.valid && in_idle;

    // Timer sits cleared in IDLE so every frame starts on a fresh bit period.
    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (in_idle),
        .enable (!in_idle),
        .tick   (tick)
    );

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: each non-idle state lasts whole bit periods, DATA lasts WIDTH of them.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (take) next_state = START;
            START: if (tick) next_state = DATA;
            DATA: begin
                if (tick && (bit_cnt == LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (tick) next_state = STOP;
`endif
            STOP:  if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Word capture on transfer, then one right shift per completed data bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift   <= '0;
            bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else if (take) begin
            shift   <= tx.data;
            bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity  <= ^tx.data;
`endif
        end else if ((state == DATA) && tick) begin
            shift   <= shift >> 1;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
        end
    end

    // Outputs decoded from registered state only, so data/valid never reach the line directly.
    always_comb begin
        serial_out = IDLE_LEVEL;
        tx.ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                tx.ready = 1'b1;
                busy     = 1'b0;
            end
            START:  serial_out = START_LEVEL;
            DATA:   serial_out = shift[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: serial_out = parity;
`endif
            STOP: begin
                serial_out = IDLE_LEVEL;
                done       = tick;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (BIT_CYCLES=4 and BIT_CYCLES=1) with a per-cycle scoreboard.
// Each accepted word pushes its expected line levels and done pulse, one entry per clock cycle.
// With an empty queue the line must be idle: high, ready, not busy, no done.
module tb_serial_tx;

    typedef struct packed {
        logic line;
        logic done;
    } ent_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    serial_tx_if #(.WIDTH(8)) if4 ();
    serial_tx_if #(.WIDTH(8)) if1 ();

    logic so4, busy4, done4;
    logic so1, busy1, done1;

    serial_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut4 (
        .clock      (clock),
        .reset      (reset),
        .tx         (if4),
        .serial_out (so4),
        .busy       (busy4),
        .done       (done4)
    );

    serial_tx #(.WIDTH(8), .BIT_CYCLES(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .tx         (if1),
        .serial_out (so1),
        .busy       (busy1),
        .done       (done1)
    );

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    ent_t q4[$];
    ent_t q1[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_bits(input int which, input int bc, input logic lvl, input bit last_done);
        ent_t e;
        for (int c = 0; c < bc; c++) begin
            e.line = lvl;
            e.done = last_done && (c == bc - 1);
            if (which == 4) q4.push_back(e);
            else            q1.push_back(e);
        end
    endtask

    // Expected frame: start 0, data LSB first, optional even parity, stop 1 with done at its end.
    task automatic push_frame(input int which, input logic [7:0] d, input int bc);
        push_bits(which, bc, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push_bits(which, bc, d[i], 1'b0);
`ifdef SERIAL_TX_PARITY_EN
        push_bits(which, bc, ^d, 1'b0);
`endif
        push_bits(which, bc, 1'b1, 1'b1);
    endtask

    // Presents d with valid high, waits for ready, and records the frame on the transfer edge.
    // Returns just after that edge with valid still high.
    task automatic send(input int which, input logic [7:0] d);
        int   n;
        logic rdy;
        n = 0;
        if (which == 4) begin if4.data = d; if4.valid = 1'b1; end
        else            begin if1.data = d; if1.valid = 1'b1; end
        @(negedge clock);
        rdy = (which == 4) ? if4.ready : if1.ready;
        while (!rdy && n < 400) begin
            @(negedge clock);
            rdy = (which == 4) ? if4.ready : if1.ready;
            n++;
        end
        if (!rdy) begin
            chk("ready_timeout", {31'd0, rdy}, 32'd1);
            if (which == 4) if4.valid = 1'b0;
            else            if1.valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            push_frame(which, d, (which == 4) ? 4 : 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 400) begin
            @(posedge clock);
            n++;
        end
        chk("drain_q4", q4.size(), 0);
        chk("drain_q1", q1.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Per-cycle compare for the BIT_CYCLES=4 instance.
    always @(negedge clock) begin : mon4
        ent_t e;
        if (mon_en) begin
            if (q4.size() != 0) begin
                e = q4.pop_front();
                chk("line4", so4, e.line);
                chk("done4", done4, e.done);
                chk("busy4", busy4, 1);
                chk("ready4", if4.ready, 0);
            end else begin
                chk("idle_line4", so4, 1);
                chk("idle_busy4", busy4, 0);
                chk("idle_ready4", if4.ready, 1);
                chk("idle_done4", done4, 0);
            end
        end
    end

    // Per-cycle compare for the BIT_CYCLES=1 instance.
    always @(negedge clock) begin : mon1
        ent_t e;
        if (mon_en) begin
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("line1", so1, e.line);
                chk("done1", done1, e.done);
                chk("busy1", busy1, 1);
                chk("ready1", if1.ready, 0);
            end else begin
                chk("idle_line1", so1, 1);
                chk("idle_busy1", busy1, 0);
                chk("idle_ready1", if1.ready, 1);
                chk("idle_done1", done1, 0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        if4.valid = 1'b0;
        if4.data  = 8'h00;
        if1.valid = 1'b0;
        if1.data  = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_line4", so4, 1);
        chk("rst_ready4", if4.ready, 1);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_line1", so1, 1);
        chk("rst_ready1", if1.ready, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (10) @(posedge clock);
        #1;

        // Single frame.
        send(4, 8'hA5);
        if4.valid = 1'b0;
        drain();

        // Back-to-back with valid held; second send changes data mid-frame.
        send(4, 8'h3C);
        send(4, 8'hFF);
        if4.valid = 1'b0;
        if4.data  = 8'h00;
        drain();

        // Reset in cycle 15 of a frame, then a clean frame.
        send(4, 8'hA5);
        if4.valid = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        q4.delete();
        send(4, 8'h01);
        if4.valid = 1'b0;
        drain();

        // Reset and valid together: nothing may be latched.
        reset     = 1'b1;
        if4.valid = 1'b1;
        if4.data  = 8'h55;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        if4.valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;

        // More patterns on the slow instance.
        send(4, 8'h00);
        if4.valid = 1'b0;
        drain();

        // One cycle per bit.
        send(1, 8'h80);
        send(1, 8'h01);
        send(1, 8'hFE);
        if1.valid = 1'b0;
        drain();

`ifdef SERIAL_TX_PARITY_EN
        send(4, 8'h07);
        if4.valid = 1'b0;
        drain();
        send(4, 8'h03);
        if4.valid = 1'b0;
        drain();
`endif

        repeat (5) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
